// File: rtl/cmult_pipe.sv
// Pipelined signed fixed-point complex multiplier, C = A*B or A*conj(B), with a
// 3-stage valid/ready pipeline, rounding and saturation. Optional ovf port: CMULT_OVF_EN.
module cmult_pipe #(
  parameter int N     = 16,
  parameter int SHIFT = N - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                conj_b,
  input  logic signed [N-1:0] Ar,
  input  logic signed [N-1:0] Ai,
  input  logic signed [N-1:0] Br,
  input  logic signed [N-1:0] Bi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] Cr,
  output logic signed [N-1:0] Ci
`ifdef CMULT_OVF_EN
  ,
  output logic                ovf
`endif
);

  localparam int PW = 2 * N;
  localparam int SW = 2 * N + 2;  // 2N+1-bit sum plus headroom for the rounding add

  localparam logic signed [N-1:0]  MAX_N = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]  MIN_N = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [SW-1:0] MAX_W = SW'(MAX_N);
  localparam logic signed [SW-1:0] MIN_W = SW'(MIN_N);

  function automatic logic signed [N-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MAX_W) return MAX_N;
    if (v < MIN_W) return MIN_N;
    return v[N-1:0];
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: operands, with B optionally conjugated
  logic                v1;
  logic signed [N-1:0] ar1, ai1, br1, bi1;
  logic signed [N-1:0] bi_eff;

  // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
  always_comb begin
    bi_eff = Bi;
    if (conj_b) bi_eff = (Bi == MIN_N) ? MAX_N : -Bi;
  end

  // Stage 2: partial products
  logic                 v2;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  // Stage 3 combinational: sums, rounding, shift
  logic signed [SW-1:0] re_sum, im_sum, re_sh, im_sh;
  assign re_sum = SW'(p_rr) - SW'(p_ii);
  assign im_sum = SW'(p_ri) + SW'(p_ir);

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [SW-1:0] HALF = SW'(1) <<< (SHIFT - 1);
      assign re_sh = (re_sum + HALF) >>> SHIFT;
      assign im_sh = (im_sum + HALF) >>> SHIFT;
    end else begin : g_noround
      assign re_sh = re_sum;
      assign im_sh = im_sum;
    end
  endgenerate

`ifdef CMULT_OVF_EN
  logic clip;
  assign clip = (re_sh > MAX_W) || (re_sh < MIN_W) || (im_sh > MAX_W) || (im_sh < MIN_W);
`endif

  // NOTE: datapath registers have no reset; their contents only matter when qualified by v1/v2.
  always_ff @(posedge clk) begin
    if (en) begin
      ar1  <= Ar;
      ai1  <= Ai;
      br1  <= Br;
      bi1  <= bi_eff;
      p_rr <= PW'(ar1) * PW'(br1);
      p_ii <= PW'(ai1) * PW'(bi1);
      p_ri <= PW'(ar1) * PW'(bi1);
      p_ir <= PW'(ai1) * PW'(br1);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      Cr        <= '0;
      Ci        <= '0;
`ifdef CMULT_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      // Results only load with a real sample so the post-reset zeros survive bubbles
      if (v2) begin
        Cr  <= sat(re_sh);
        Ci  <= sat(im_sh);
`ifdef CMULT_OVF_EN
        ovf <= clip;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cmult_pipe.sv
// Scoreboard bench for cmult_pipe: directed corner cases, backpressure, mid-run
// reset and randomized traffic against a plain-arithmetic reference model.
module tb_cmult_pipe;

  localparam int N     = 16;
  localparam int SHIFT = 15;
  localparam int MAXV  = (1 << (N - 1)) - 1;
  localparam int MINV  = -(1 << (N - 1));

  typedef struct {
    int cr;
    int ci;
    bit ovf;
  } res_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic                conj_b;
  logic signed [N-1:0] Ar, Ai, Br, Bi;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] Cr, Ci;
`ifdef CMULT_OVF_EN
  logic                ovf;
`endif

  int   total = 0;
  int   bad   = 0;
  res_t sb[$];
  int   stall_left = 0;
  bit   rand_bp    = 1'b0;

  cmult_pipe #(.N(N), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .conj_b    (conj_b),
    .Ar        (Ar),
    .Ai        (Ai),
    .Br        (Br),
    .Bi        (Bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Cr        (Cr),
    .Ci        (Ci)
`ifdef CMULT_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: exact integer arithmetic, floor((x + half) / 2^SHIFT), clamp.
  function automatic longint scale(input longint v);
    if (SHIFT == 0) return v;
    return (v + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
  endfunction

  function automatic int clamp(input longint v, inout bit flag);
    if (v > MAXV) begin flag = 1'b1; return MAXV; end
    if (v < MINV) begin flag = 1'b1; return MINV; end
    return int'(v);
  endfunction

  function automatic res_t model(input int ar, input int ai, input int br, input int bi, input bit cj);
    res_t   r;
    longint bie, re, im;
    bie   = cj ? ((bi == MINV) ? longint'(MAXV) : -longint'(bi)) : longint'(bi);
    re    = longint'(ar) * br - longint'(ai) * bie;
    im    = longint'(ar) * bie + longint'(ai) * br;
    r.ovf = 1'b0;
    r.cr  = clamp(scale(re), r.ovf);
    r.ci  = clamp(scale(im), r.ovf);
    return r;
  endfunction

  function automatic int rnd_op();
    case ($urandom_range(0, 7))
      0:       return MINV;
      1:       return MAXV;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // Present one sample, wait (bounded) for acceptance, record its expected result.
  task automatic send(input int ar, input int ai, input int br, input int bi, input bit cj,
                      input res_t exp);
    int n;
    n        = 0;
    Ar       = N'(ar);
    Ai       = N'(ai);
    Br       = N'(br);
    Bi       = N'(bi);
    conj_b   = cj;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Call right after send() into an empty pipeline with out_ready high.
  task automatic expect_latency(input string name);
    check({name, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    check({name, "_lat2"}, out_valid, 0);
    @(posedge clk); #1;
    check({name, "_lat3"}, out_valid, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
  endtask

  // Downstream readiness: forced stall window, random backpressure, or always ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_bp) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: handshake rule, hold-under-stall, and scoreboard comparison.
  initial begin
    bit                  prev_stall;
    logic signed [N-1:0] held_cr, held_ci;
    res_t                e;
    prev_stall = 1'b0;
    held_cr    = '0;
    held_ci    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("in_ready_rule", in_ready, (!out_valid || out_ready));
        if (out_valid && !out_ready) begin
          if (prev_stall) begin
            check("hold_cr", Cr, held_cr);
            check("hold_ci", Ci, held_ci);
          end
          held_cr    = Cr;
          held_ci    = Ci;
          prev_stall = 1'b1;
        end else begin
          prev_stall = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: Cr=%0d Ci=%0d with empty scoreboard", Cr, Ci);
          end else begin
            e = sb.pop_front();
            check("cr", Cr, e.cr);
            check("ci", Ci, e.ci);
`ifdef CMULT_OVF_EN
            check("ovf", ovf, e.ovf);
`endif
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    conj_b   = 1'b0;
    Ar = '0; Ai = '0; Br = '0; Bi = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_cr", Cr, 0);
    check("rst_ci", Ci, 0);
`ifdef CMULT_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Basic multiply with latency check
    send(16384, 16384, 16384, -16384, 1'b0, res_t'{16384, 0, 1'b0});
    expect_latency("basic");
    wait_idle();

    // Conjugate, saturation and rounding corners, back-to-back
    send(0, 16384, 0, 16384, 1'b1, res_t'{8192, 0, 1'b0});
    send(0, 16384, 0, 16384, 1'b0, res_t'{-8192, 0, 1'b0});
    send(0, 16384, 0, -32768, 1'b1, res_t'{-16383, 0, 1'b0});
    send(-32768, 0, -32768, 0, 1'b0, res_t'{32767, 0, 1'b1});
    send(-32768, 0, 0, -32768, 1'b0, res_t'{0, 32767, 1'b1});
    send(-32768, -32768, 32767, -32768, 1'b0, res_t'{-32768, 1, 1'b1});
    send(1, 0, 16384, 0, 1'b0, res_t'{1, 0, 1'b0});
    send(-1, 0, 16384, 0, 1'b0, res_t'{0, 0, 1'b0});
    send(-1, 0, -16384, 0, 1'b0, res_t'{1, 0, 1'b0});
    wait_idle();

    // Backpressure: 8 back-to-back samples with a 4-cycle stall mid-stream
    fork
      for (int k = 1; k <= 8; k++) send(k, 0, 32767, 0, 1'b0, res_t'{k, 0, 1'b0});
      begin
        repeat (4) @(posedge clk);
        stall_left = 4;
      end
    join
    wait_idle();

    // Reset with three samples in flight
    for (int k = 0; k < 3; k++) send(1000 + k, 0, 32767, 0, 1'b0, res_t'{1000 + k, 0, 1'b0});
    check("pre_reset_valid", out_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_cr", Cr, 0);
    check("mid_rst_ci", Ci, 0);
`ifdef CMULT_OVF_EN
    check("mid_rst_ovf", ovf, 0);
`endif
    sb.delete();
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_stale", out_valid, 0);
    send(-20000, 12345, 30000, -777, 1'b1, model(-20000, 12345, 30000, -777, 1'b1));
    expect_latency("post_rst");
    wait_idle();

    // Randomized traffic with random gaps and backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int ar, ai, br, bi;
      bit cj;
      ar = rnd_op();
      ai = rnd_op();
      br = rnd_op();
      bi = rnd_op();
      cj = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(ar, ai, br, bi, cj, model(ar, ai, br, bi, cj));
    end
    rand_bp = 1'b0;
    wait_idle();

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
